// File: rtl/hazard_forwarding_unit.sv
// hazard_forwarding_unit
//   Drives the ID-stage mux selects for a 5-stage pipeline. These are the rs1/rs2
//   forwarding selects and the control-unit bubble select. It also drives the PC and
//   IF/ID load enables and the IF/ID flush.
//   Hazard detection uses a private shadow copy of the EX/MEM/WB destination info.
//   Every output is combinational from the current inputs and the shadow registers.
//   Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cnt/flush_cnt
//   performance counters.
module hazard_forwarding_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_rs1,
    input  logic [REG_AW-1:0] ID_rs2,
    input  logic              ID_use_rs1,
    input  logic              ID_use_rs2,
    input  logic [REG_AW-1:0] ID_rd,
    input  logic              ID_RF_Enable,
    input  logic              ID_Load_Instr,
    input  logic              EX_branch_taken,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              cu_mux_sel,
    output logic              PC_LE,
    output logic              IFID_LE,
    output logic              IFID_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Forwarding select encodings
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Pipeline control situation for the current cycle, derived from the shadow state
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // A zero-width counter is meaningless, so reject it at elaboration.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_forwarding_unit: CNT_W must be at least 1");
    end

    // A stage produces a value for this operand only if it writes a non-zero
    // register equal to the operand, and the ID instruction really reads that operand.
    function automatic logic f_match(input logic              rf_en,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              use_rs);
        return rf_en & (rd != {REG_AW{1'b0}}) & (rd == rs) & use_rs;
    endfunction

    // Select priority is EX > MEM > WB > RF. A load in EX cannot forward because its
    // data is not available yet, so that case falls through to the older stages.
    function automatic logic [1:0] f_fwd_sel(input logic ex_m, input logic ex_load,
                                             input logic mem_m, input logic wb_m);
        logic [1:0] sel;
        if (ex_m && !ex_load) begin
            sel = SEL_EX;
        end else if (mem_m) begin
            sel = SEL_MEM;
        end else if (wb_m) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Shadow EX/MEM/WB stage registers
    logic [REG_AW-1:0] r_ex_rd,  r_mem_rd,  r_wb_rd;
    logic              r_ex_rf,  r_mem_rf,  r_wb_rf;
    logic              r_ex_ld,  r_mem_ld,  r_wb_ld;

    logic              w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
    logic              w_load_use;
    state_t            w_state;

    assign w_ex_m1    = f_match(r_ex_rf,  r_ex_rd,  ID_rs1, ID_use_rs1);
    assign w_ex_m2    = f_match(r_ex_rf,  r_ex_rd,  ID_rs2, ID_use_rs2);
    assign w_mem_m1   = f_match(r_mem_rf, r_mem_rd, ID_rs1, ID_use_rs1);
    assign w_mem_m2   = f_match(r_mem_rf, r_mem_rd, ID_rs2, ID_use_rs2);
    assign w_wb_m1    = f_match(r_wb_rf,  r_wb_rd,  ID_rs1, ID_use_rs1);
    assign w_wb_m2    = f_match(r_wb_rf,  r_wb_rd,  ID_rs2, ID_use_rs2);
    assign w_load_use = r_ex_ld & (w_ex_m1 | w_ex_m2);

    // Classify the cycle; a taken branch overrides a load-use stall
    always_comb begin
        w_state = ST_RUN;
        if (EX_branch_taken) begin
            w_state = ST_FLUSH;
        end else if (w_load_use) begin
            w_state = ST_STALL;
        end else begin
            w_state = ST_RUN;
        end
    end

    // Drive mux selects and enables; reset forces the bubble/flush pattern
    always_comb begin
        fwd_rs1_sel = SEL_RF;
        fwd_rs2_sel = SEL_RF;
        cu_mux_sel  = 1'b0;
        PC_LE       = 1'b1;
        IFID_LE     = 1'b1;
        IFID_flush  = 1'b0;
        if (reset) begin
            cu_mux_sel = 1'b1;
            IFID_flush = 1'b1;
        end else begin
            fwd_rs1_sel = f_fwd_sel(w_ex_m1, r_ex_ld, w_mem_m1, w_wb_m1);
            fwd_rs2_sel = f_fwd_sel(w_ex_m2, r_ex_ld, w_mem_m2, w_wb_m2);
            case (w_state)
                ST_RUN: begin
                    cu_mux_sel = 1'b0;
                end
                ST_STALL: begin
                    cu_mux_sel = 1'b1;
                    PC_LE      = 1'b0;
                    IFID_LE    = 1'b0;
                end
                ST_FLUSH: begin
                    cu_mux_sel = 1'b1;
                    IFID_flush = 1'b1;
                end
                default: begin
                    cu_mux_sel = 1'b1;
                    IFID_flush = 1'b1;
                end
            endcase
        end
    end

    // Advance the shadow pipeline; a bubble enters EX whenever the CU mux is zeroed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_rd  <= {REG_AW{1'b0}};
            r_ex_rf  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_mem_rd <= {REG_AW{1'b0}};
            r_mem_rf <= 1'b0;
            r_mem_ld <= 1'b0;
            r_wb_rd  <= {REG_AW{1'b0}};
            r_wb_rf  <= 1'b0;
            r_wb_ld  <= 1'b0;
        end else begin
            if (cu_mux_sel) begin
                r_ex_rd <= {REG_AW{1'b0}};
                r_ex_rf <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_rd <= ID_rd;
                r_ex_rf <= ID_RF_Enable;
                r_ex_ld <= ID_Load_Instr;
            end
            r_mem_rd <= r_ex_rd;
            r_mem_rf <= r_ex_rf;
            r_mem_ld <= r_ex_ld;
            r_wb_rd  <= r_mem_rd;
            r_wb_rf  <= r_mem_rf;
            r_wb_ld  <= r_mem_ld;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Count stall and flush cycles; both counters wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_state == ST_STALL) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed testbench for hazard_forwarding_unit. The optional counter checks are
// compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_forwarding_unit;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] ID_rs1, ID_rs2, ID_rd;
    logic              ID_use_rs1, ID_use_rs2, ID_RF_Enable, ID_Load_Instr;
    logic              EX_branch_taken;
    logic [1:0]        fwd_rs1_sel, fwd_rs2_sel;
    logic              cu_mux_sel, PC_LE, IFID_LE, IFID_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    hazard_forwarding_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .ID_rd(ID_rd), .ID_RF_Enable(ID_RF_Enable), .ID_Load_Instr(ID_Load_Instr),
        .EX_branch_taken(EX_branch_taken),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .cu_mux_sel(cu_mux_sel), .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IFID_flush(IFID_flush)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One clock edge; returns just after the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one ID instruction: rs1, use1, rs2, use2, rd, rf_en, load
    task automatic set_id(input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rf, input bit ld);
        ID_rs1 = rs1[REG_AW-1:0];  ID_use_rs1 = u1;
        ID_rs2 = rs2[REG_AW-1:0];  ID_use_rs2 = u2;
        ID_rd  = rd[REG_AW-1:0];   ID_RF_Enable = rf;  ID_Load_Instr = ld;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        EX_branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        EX_branch_taken = 1'b0;
        set_id(3, 1, 4, 1, 3, 1, 0);
        checks++; if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin errors++; $display("FAIL rst_fwd: got %b want 0000", {fwd_rs1_sel, fwd_rs2_sel}); end
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b1111) begin errors++; $display("FAIL rst_ctl: got %b want 1111", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        set_id(0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        #1;
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b0110) begin errors++; $display("FAIL post_rst_idle: got %b want 0110", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
    endtask

    task automatic test_ex_forward();
        do_reset();
        set_id(0, 0, 0, 0, 5, 1, 0);           // ADD x5
        step();
        set_id(5, 1, 0, 0, 6, 1, 0);           // reads x5 as rs1
        checks++; if (fwd_rs1_sel !== 2'b01) begin errors++; $display("FAIL ex_fwd_rs1: got %b want 01", fwd_rs1_sel); end
        checks++; if (fwd_rs2_sel !== 2'b00) begin errors++; $display("FAIL ex_fwd_rs2: got %b want 00", fwd_rs2_sel); end
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE} !== 3'b011) begin errors++; $display("FAIL ex_fwd_nostall: got %b want 011", {cu_mux_sel, PC_LE, IFID_LE}); end
    endtask

    task automatic test_priority();
        do_reset();
        set_id(0, 0, 0, 0, 5, 1, 0);
        step();
        set_id(0, 0, 0, 0, 5, 1, 0);
        step();                                 // EX=x5, MEM=x5
        set_id(0, 0, 5, 1, 0, 0, 0);            // non-writing reader of rs2=x5
        checks++; if (fwd_rs2_sel !== 2'b01) begin errors++; $display("FAIL prio_ex: got %b want 01", fwd_rs2_sel); end
        step();                                 // EX=nop, MEM=x5, WB=x5
        checks++; if (fwd_rs2_sel !== 2'b10) begin errors++; $display("FAIL prio_mem: got %b want 10", fwd_rs2_sel); end
        step();                                 // only WB=x5
        checks++; if (fwd_rs2_sel !== 2'b11) begin errors++; $display("FAIL prio_wb: got %b want 11", fwd_rs2_sel); end
        step();                                 // x5 has left the pipeline
        checks++; if (fwd_rs2_sel !== 2'b00) begin errors++; $display("FAIL prio_rf: got %b want 00", fwd_rs2_sel); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(0, 0, 0, 0, 7, 1, 1);            // LW x7
        step();
        set_id(7, 1, 0, 0, 8, 1, 0);            // reads x7
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b1000) begin errors++; $display("FAIL lu_stall: got %b want 1000", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        checks++; if (fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL lu_nofwd: got %b want 00", fwd_rs1_sel); end
        step();                                 // bubble in EX, LW in MEM
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b0110) begin errors++; $display("FAIL lu_release: got %b want 0110", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        checks++; if (fwd_rs1_sel !== 2'b10) begin errors++; $display("FAIL lu_memfwd: got %b want 10", fwd_rs1_sel); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_id(0, 0, 0, 0, 7, 1, 1);
        step();
        set_id(0, 0, 7, 1, 8, 1, 0);
        EX_branch_taken = 1'b1;
        #1;
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b1111) begin errors++; $display("FAIL br_over_stall: got %b want 1111", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        step();
        EX_branch_taken = 1'b0;
        #1;
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b0110) begin errors++; $display("FAIL br_no_stall_after: got %b want 0110", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        checks++; if (fwd_rs2_sel !== 2'b10) begin errors++; $display("FAIL br_memfwd: got %b want 10", fwd_rs2_sel); end
        EX_branch_taken = 1'b1;
        #1;
        checks++; if (IFID_flush !== 1'b1) begin errors++; $display("FAIL br_b2b_1: got %b want 1", IFID_flush); end
        step();
        checks++; if (IFID_flush !== 1'b1) begin errors++; $display("FAIL br_b2b_2: got %b want 1", IFID_flush); end
        EX_branch_taken = 1'b0;
        #1;
    endtask

    task automatic test_x0_and_use();
        do_reset();
        set_id(0, 0, 0, 0, 0, 1, 0);            // writes x0
        step();
        set_id(0, 1, 0, 1, 1, 1, 0);
        checks++; if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin errors++; $display("FAIL x0_nofwd: got %b want 0000", {fwd_rs1_sel, fwd_rs2_sel}); end
        set_id(0, 0, 0, 0, 9, 1, 0);            // writes x9
        step();
        set_id(9, 0, 9, 1, 1, 1, 0);            // rs1 unused, rs2 used
        checks++; if (fwd_rs1_sel !== 2'b00) begin errors++; $display("FAIL unused_rs1: got %b want 00", fwd_rs1_sel); end
        checks++; if (fwd_rs2_sel !== 2'b01) begin errors++; $display("FAIL used_rs2: got %b want 01", fwd_rs2_sel); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(0, 0, 0, 0, 7, 1, 1);
        step();
        set_id(7, 1, 0, 0, 8, 1, 0);
        checks++; if (PC_LE !== 1'b0) begin errors++; $display("FAIL rms_stall: got %b want 0", PC_LE); end
        reset = 1'b1;
        #1;
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush} !== 4'b1111) begin errors++; $display("FAIL rms_forced: got %b want 1111", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush}); end
        step();
        reset = 1'b0;
        #1;
        checks++; if ({cu_mux_sel, PC_LE, IFID_LE, IFID_flush, fwd_rs1_sel} !== 6'b011000) begin errors++; $display("FAIL rms_idle: got %b want 011000", {cu_mux_sel, PC_LE, IFID_LE, IFID_flush, fwd_rs1_sel}); end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL cnt_init: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        for (int i = 0; i < 3; i++) begin
            set_id(0, 0, 0, 0, 7, 1, 1);
            step();
            set_id(7, 1, 0, 0, 8, 1, 0);
            step();
        end
        EX_branch_taken = 1'b1;
        step();
        step();
        EX_branch_taken = 1'b0;
        #1;
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL cnt_stall: got %0d want 3", stall_cnt); end
        checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL cnt_flush: got %0d want 2", flush_cnt); end
        do_reset();
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        EX_branch_taken = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_branch_flush();
        test_x0_and_use();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
